// File: rtl/cpu_pkg.sv
// Shared CPU datapath package: word/address widths and the types used by the
// register file, operand muxes, ALU and instruction decoder.
package cpu_pkg;

    localparam int DATA_W    = 8;
    localparam int ADDR_W    = 3;
    localparam int REG_COUNT = 1 << ADDR_W;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] word_t;

endpackage : cpu_pkg

// File: rtl/decoder_3to8.sv
// Enabled binary-to-one-hot decoder. Used as the register file write demux
// and intended for memory bank select as well.
module decoder_3to8
    import cpu_pkg::*;
#(
    parameter int ADDR_W = cpu_pkg::ADDR_W
) (
    input  logic                   en,
    input  logic [ADDR_W-1:0]      addr,
    output logic [(1<<ADDR_W)-1:0] onehot
);

    localparam int COUNT = 1 << ADDR_W;

    // One output line per address; at most one line is high, none when en=0.
    for (genvar gi = 0; gi < COUNT; gi++) begin : g_line
        assign onehot[gi] = en && (addr == ADDR_W'(gi));
    end

endmodule : decoder_3to8

// File: rtl/reg_file.sv
// 8 x 8 CPU register file: one decoded write port, two combinational read
// ports, optional write-to-read forwarding.
module reg_file
    import cpu_pkg::*;
#(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W,
    parameter int BYPASS = 0
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [DATA_W-1:0] IN,
    input  logic [ADDR_W-1:0] INADDRESS,
    input  logic              WRITE,
    input  logic              BUSYWAIT,
    input  logic [ADDR_W-1:0] OUT1ADDRESS,
    input  logic [ADDR_W-1:0] OUT2ADDRESS,
    output logic [DATA_W-1:0] OUT1,
    output logic [DATA_W-1:0] OUT2
);

    localparam int NREGS  = 1 << ADDR_W;
    localparam int NPORTS = 2;

    logic [DATA_W-1:0] mem_reg [NREGS];
    logic [NREGS-1:0]  wr_onehot;
    logic              wr_en;
    logic              wr_any;
    logic              fwd_ok;

    // A stall holds the write off; the control unit keeps the request stable
    // so it lands on the first non-stalled edge.
    assign wr_en = WRITE && !BUSYWAIT;

    decoder_3to8 #(
        .ADDR_W (ADDR_W)
    ) u_wr_demux (
        .en     (wr_en),
        .addr   (INADDRESS),
        .onehot (wr_onehot)
    );

    assign wr_any = |wr_onehot;

    // Forwarding mirrors exactly the write that will happen at the next edge:
    // no forwarding while stalled or while reset is about to clear the file.
    assign fwd_ok = (BYPASS != 0) && wr_any && !RESET;

    // Register storage: reset clears everything and discards any pending write.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (wr_onehot[i]) begin
                    mem_reg[i] <= IN;
                end
            end
        end
    end

    // Both read ports share the same select-plus-forward structure.
    logic [ADDR_W-1:0] rd_addr [NPORTS];
    logic [DATA_W-1:0] rd_data [NPORTS];

    assign rd_addr[0] = OUT1ADDRESS;
    assign rd_addr[1] = OUT2ADDRESS;

    for (genvar gi = 0; gi < NPORTS; gi++) begin : g_rd_port
        assign rd_data[gi] = (fwd_ok && (rd_addr[gi] == INADDRESS)) ? IN
                                                                    : mem_reg[rd_addr[gi]];
    end

    assign OUT1 = rd_data[0];
    assign OUT2 = rd_data[1];

endmodule : reg_file

// File: doc/reg_file.md
# reg_file

8-entry × 8-bit register file for the single-cycle CPU datapath.
- Write side: the 3-bit write address is decoded one-hot and routes the single write-data bus to exactly one register. This is the demux counterpart of the 2:1 operand/result muxes.
- Read side: two independent asynchronous read ports feed the ALU operand muxes.
- Sits between the instruction decoder/control unit (addresses, WRITE) and the ALU/data-memory result mux (IN).

## Interface
Parameters:
- DATA_W, 8, register width
- ADDR_W, 3, address width; register count is 2**ADDR_W
- BYPASS, 0, 1 = a read port addressing the register being written this cycle returns IN; 0 = returns the stored value

Ports:
- CLK  input  1  clock; all state updates on rising edge
- RESET  input  1  synchronous, active-high; clears all registers at the rising edge
- IN  input  DATA_W  write data
- INADDRESS  input  ADDR_W  write address
- WRITE  input  1  write enable
- BUSYWAIT  input  1  memory stall; suppresses writes while high
- OUT1ADDRESS  input  ADDR_W  read port 1 address
- OUT2ADDRESS  input  ADDR_W  read port 2 address
- OUT1  output  DATA_W  read port 1 data
- OUT2  output  DATA_W  read port 2 data

## Operation
- Storage: regs[0..7], DATA_W bits each. All eight are general purpose and writable; none is hardwired.
- Write decode:
  - wr_onehot = WRITE && !BUSYWAIT ? (1 << INADDRESS) : 0.
  - At most one bit of wr_onehot is set.
- Rising-edge update, priority order:
  1. RESET=1: all regs ← 0. WRITE and BUSYWAIT are ignored.
  2. Otherwise, for each i with wr_onehot[i]=1: regs[i] ← IN.
  3. All other registers hold.
- Reads are combinational:
  - OUT1 = regs[OUT1ADDRESS]; OUT2 = regs[OUT2ADDRESS].
  - Both ports may address the same register; both then show the same value.
- Bypass (BYPASS=1 only):
  - If wr_onehot is active, RESET=0, and OUTnADDRESS==INADDRESS, then OUTn = IN.
  - The bypass is gated by BUSYWAIT and RESET exactly like the write it forwards.
- Invalid address: none exists, since ADDR_W fully covers 2**ADDR_W registers. X on any address input may propagate X to the outputs; no other guarding is required.

## Timing
- Write latency: one edge. Data presented in cycle N is visible on a read port after edge N, in cycle N+1 (BYPASS=0).
- Read latency: 0 cycles, combinational from address/register change.
- Reset values:
  - all regs = 0x00;
  - OUT1 = OUT2 = 0x00 from the cycle after the reset edge, regardless of addresses.
- Read/write same address, same cycle:
  - BYPASS=0: old value until the edge, new value after it.
  - BYPASS=1: new value immediately.
- BUSYWAIT high on an edge with WRITE=1: no register changes. The control unit holds WRITE/IN/INADDRESS stable, and the write completes on the first edge with BUSYWAIT=0.
- RESET asserted mid-stall or on a write edge: reset wins and the pending write is lost.
- Back-to-back writes to the same address on consecutive edges: the last write wins; there is no hazard state.

## Structure
- Shared package cpu_pkg:
  - DATA_W=8, ADDR_W=3;
  - REG_COUNT = 1<<ADDR_W;
  - reg_addr_t (ADDR_W bits) and word_t (DATA_W bits) typedefs, also reused by the mux, ALU and decoder.
- Sub-module decoder_3to8 (ADDR_W→REG_COUNT one-hot with enable):
  - instantiated once for the write demux;
  - reused later for memory bank select.
- Read ports are two instances of the same indexed-select logic, inline; no separate module.

## Test plan
- Reset clear: preload regs[i]=0x10+i, assert RESET one edge → all eight read back 0x00 on both ports.
- Basic write/read:
  - write 0x2A to r3 → next cycle OUT1(addr 3)=0x2A and OUT2(addr 3)=0x2A;
  - all other registers unchanged.
- Same-cycle read of write target, r5 old value 0x11, IN=0x77:
  - BYPASS=0 → OUT1=0x11 before the edge, 0x77 after;
  - BYPASS=1 → OUT1=0x77 before the edge.
- Stall: WRITE=1, INADDRESS=2, IN=0xC3, BUSYWAIT=1 for 3 edges, then 0:
  - r2 unchanged through the stall;
  - r2=0xC3 after the first edge with BUSYWAIT=0.
- Reset priority: RESET=1 and WRITE=1 (r7 ← 0xFF) on the same edge → r7=0x00.
- Full sweep:
  - write r0..r7 = 0xA0..0xA7 on 8 consecutive edges;
  - read all 64 (OUT1ADDRESS, OUT2ADDRESS) pairs → each port returns 0xA0+addr.
